// File: rtl/rc4_key_crack_core.sv
// RC4 key-search worker: runs KSA + PRGA for one 24-bit key over a 32-byte
// ciphertext and reports whether the plaintext is lowercase letters/spaces only.
module rc4_key_crack_core #(
  parameter ROM_FILE  = "message.mif",
  parameter int MSG_LEN   = 32,
  parameter int KEY_BYTES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] secret_key_raw,
  output logic        finish,
  output logic        valid
);

  localparam int KW = $clog2(MSG_LEN);
  localparam logic [KW-1:0] K_LAST   = KW'(MSG_LEN - 1);
  localparam logic [1:0]    KEY_LAST = 2'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    INIT, KSA_RD_I, KSA_RD_J, KSA_WR_I, KSA_WR_J,
    PRGA_INC, PRGA_RD_I, PRGA_RD_J, PRGA_WR_I, PRGA_WR_J, PRGA_RD_F,
    CHECK, DONE
  } state_t;

  state_t state, state_d;
  logic [7:0]    i, i_d, j, j_d, si, si_d, sj, sj_d;
  logic [KW-1:0] k, k_d;
  logic [1:0]    key_idx, key_idx_d;
  logic [23:0]   key_reg, key_d;
  logic          valid_q, valid_d;

  logic [7:0] s_mem [256];
  logic [7:0] s_addr, s_wdata, s_rdata;
  logic       s_we;

  (* ram_init_file = ROM_FILE *) logic [7:0] rom [MSG_LEN];
  logic [7:0] rom_q;

  logic [7:0] key_byte, ksa_j, prga_j, plain;
  logic       plain_ok;

  // Key byte for the current KSA step; key[0] is the most significant byte.
  always_comb begin
    case (key_idx)
      2'd0:    key_byte = key_reg[23:16];
      2'd1:    key_byte = key_reg[15:8];
      default: key_byte = key_reg[7:0];
    endcase
  end

  assign ksa_j    = j + s_rdata + key_byte;
  assign prga_j   = j + s_rdata;
  assign plain    = s_rdata ^ rom_q;
  assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);

  // S-box RAM: single port, read-before-write, one cycle read latency.
  always_ff @(posedge clk) begin
    if (s_we) s_mem[s_addr] <= s_wdata;
    s_rdata <= s_mem[s_addr];
  end

  // Ciphertext ROM read, addressed by the current byte index.
  always_ff @(posedge clk) begin
    rom_q <= rom[k];
  end

  // State and datapath registers, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= INIT;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      si      <= '0;
      sj      <= '0;
      key_idx <= '0;
      key_reg <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_d;
      i       <= i_d;
      j       <= j_d;
      k       <= k_d;
      si      <= si_d;
      sj      <= sj_d;
      key_idx <= key_idx_d;
      key_reg <= key_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, RAM control and index arithmetic for the KSA/PRGA sequence.
  always_comb begin
    state_d   = state;
    i_d       = i;
    j_d       = j;
    k_d       = k;
    si_d      = si;
    sj_d      = sj;
    key_idx_d = key_idx;
    key_d     = key_reg;
    valid_d   = valid_q;
    s_addr    = i;
    s_wdata   = i;
    s_we      = 1'b0;
    case (state)
      INIT: begin
        if (i == 8'd0) key_d = secret_key_raw;
        s_we = 1'b1;
        i_d  = i + 8'd1;
        if (i == 8'd255) begin
          j_d       = '0;
          key_idx_d = '0;
          state_d   = KSA_RD_I;
        end
      end
      KSA_RD_I: state_d = KSA_RD_J;
      KSA_RD_J: begin
        si_d    = s_rdata;
        j_d     = ksa_j;
        s_addr  = ksa_j;
        state_d = KSA_WR_I;
      end
      KSA_WR_I: begin
        s_we    = 1'b1;
        s_wdata = s_rdata;
        state_d = KSA_WR_J;
      end
      KSA_WR_J: begin
        s_we      = 1'b1;
        s_addr    = j;
        s_wdata   = si;
        i_d       = i + 8'd1;
        key_idx_d = (key_idx == KEY_LAST) ? 2'd0 : key_idx + 2'd1;
        if (i == 8'd255) begin
          j_d     = '0;
          k_d     = '0;
          state_d = PRGA_INC;
        end else begin
          state_d = KSA_RD_I;
        end
      end
      PRGA_INC: begin
        i_d     = i + 8'd1;
        state_d = PRGA_RD_I;
      end
      PRGA_RD_I: state_d = PRGA_RD_J;
      PRGA_RD_J: begin
        si_d    = s_rdata;
        j_d     = prga_j;
        s_addr  = prga_j;
        state_d = PRGA_WR_I;
      end
      PRGA_WR_I: begin
        sj_d    = s_rdata;
        s_we    = 1'b1;
        s_wdata = s_rdata;
        state_d = PRGA_WR_J;
      end
      PRGA_WR_J: begin
        s_we    = 1'b1;
        s_addr  = j;
        s_wdata = si;
        state_d = PRGA_RD_F;
      end
      PRGA_RD_F: begin
        s_addr  = si + sj;
        state_d = CHECK;
      end
      CHECK: begin
        if (!plain_ok) begin
          valid_d = 1'b0;
          state_d = DONE;
        end else if (k == K_LAST) begin
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          k_d     = k + 1'b1;
          state_d = PRGA_INC;
        end
      end
      default: state_d = DONE;
    endcase
  end

  assign finish = (state == DONE);
  assign valid  = valid_q;

endmodule

// File: tb/tb_rc4_key_crack_core.sv
// Directed bench for rc4_key_crack_core: builds ciphertext ROMs with a software
// RC4 model, loads them into the core, and checks finish/valid and timing.
module tb_rc4_key_crack_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] secret_key_raw;
  logic        finish;
  logic        valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] pt_buf   [32];
  logic [7:0] rom_img  [32];
  logic [7:0] model_ks [32];
  logic [7:0] bad_chars [4] = '{8'h60, 8'h7B, 8'h1F, 8'h41};

  int lat_golden, lat_run;
  logic exp_valid;

  rc4_key_crack_core #(
    .ROM_FILE ("message.mif"),
    .MSG_LEN  (32),
    .KEY_BYTES(3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .secret_key_raw(secret_key_raw),
    .finish        (finish),
    .valid         (valid)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Reference RC4 keystream for the first 32 bytes.
  function automatic void model_keystream(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] a, b, t;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    b = 8'd0;
    for (int n = 0; n < 256; n++) begin
      b = b + s[n] + kb[n % 3];
      t = s[n]; s[n] = s[b]; s[b] = t;
    end
    a = 8'd0;
    b = 8'd0;
    for (int n = 0; n < 32; n++) begin
      a = a + 8'd1;
      b = b + s[a];
      t = s[a]; s[a] = s[b]; s[b] = t;
      model_ks[n] = s[8'(s[a] + s[b])];
    end
  endfunction

  function automatic void encrypt_plaintext(input logic [23:0] key);
    model_keystream(key);
    for (int n = 0; n < 32; n++) rom_img[n] = pt_buf[n] ^ model_ks[n];
  endfunction

  function automatic logic model_accept(input logic [23:0] key);
    logic [7:0] p;
    model_keystream(key);
    for (int n = 0; n < 32; n++) begin
      p = rom_img[n] ^ model_ks[n];
      if (!(((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20))) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void load_sentence();
    string txt;
    txt = "the quick brown fox jumps over t";
    for (int n = 0; n < 32; n++) pt_buf[n] = txt[n];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Reset the core with a new key and ROM image, then wait (bounded) for finish.
  task automatic applyStimulus(input string tag, input logic [23:0] key, output int lat);
    @(negedge clk);
    reset = 1'b0;
    secret_key_raw = key;
    for (int n = 0; n < 32; n++) dut.rom[n] = rom_img[n];
    #1;
    checkOutput({tag, "_rst_finish"}, {31'd0, finish}, 32'd0);
    checkOutput({tag, "_rst_valid"}, {31'd0, valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    lat = 0;
    while (finish !== 1'b1 && lat < 3000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_finish"}, {31'd0, finish}, 32'd1);
    checkOutput({tag, "_latency_le_2500"}, {31'd0, lat <= 2500}, 32'd1);
  endtask

  // Directed sequence of trials.
  initial begin
    reset = 1'b1;
    secret_key_raw = 24'h0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_finish", {31'd0, finish}, 32'd0);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);

    load_sentence();
    encrypt_plaintext(24'h000123);
    applyStimulus("golden", 24'h000123, lat_golden);
    checkOutput("golden_valid", {31'd0, valid}, 32'd1);

    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      secret_key_raw = 24'($urandom);
      @(posedge clk);
      #1;
      checkOutput("sticky_finish", {31'd0, finish}, 32'd1);
      checkOutput("sticky_valid", {31'd0, valid}, 32'd1);
    end

    exp_valid = model_accept(24'h000124);
    applyStimulus("wrong", 24'h000124, lat_run);
    checkOutput("wrong_valid", {31'd0, valid}, {31'd0, exp_valid});
    checkOutput("wrong_earlier", {31'd0, lat_run < lat_golden}, 32'd1);

    for (int n = 0; n < 32; n++)
      pt_buf[n] = (n % 3 == 0) ? 8'h61 : ((n % 3 == 1) ? 8'h7A : 8'h20);
    encrypt_plaintext(24'h000000);
    applyStimulus("bound_ok", 24'h000000, lat_run);
    checkOutput("bound_ok_valid", {31'd0, valid}, 32'd1);
    checkOutput("bound_ok_latency", lat_run, lat_golden);

    for (int b = 0; b < 4; b++) begin
      pt_buf[31] = bad_chars[b];
      encrypt_plaintext(24'h000000);
      applyStimulus("bound_bad", 24'h000000, lat_run);
      checkOutput("bound_bad_valid", {31'd0, valid}, 32'd0);
      checkOutput("bound_bad_latency", lat_run, lat_golden);
    end

    load_sentence();
    encrypt_plaintext(24'hFFFFFF);
    exp_valid = model_accept(24'hFFFFFF);
    applyStimulus("key_ffffff", 24'hFFFFFF, lat_run);
    checkOutput("key_ffffff_valid", {31'd0, valid}, {31'd0, exp_valid});

    encrypt_plaintext(24'h800000);
    exp_valid = model_accept(24'h800000);
    applyStimulus("key_800000", 24'h800000, lat_run);
    checkOutput("key_800000_valid", {31'd0, valid}, {31'd0, exp_valid});
    exp_valid = model_accept(24'h000080);
    applyStimulus("key_000080", 24'h000080, lat_run);
    checkOutput("key_000080_valid", {31'd0, valid}, {31'd0, exp_valid});

    load_sentence();
    encrypt_plaintext(24'h000123);
    @(negedge clk);
    reset = 1'b0;
    secret_key_raw = 24'h000124;
    for (int n = 0; n < 32; n++) dut.rom[n] = rom_img[n];
    @(negedge clk);
    reset = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    checkOutput("midtrial_busy", {31'd0, finish}, 32'd0);
    applyStimulus("midtrial", 24'h000123, lat_run);
    checkOutput("midtrial_valid", {31'd0, valid}, 32'd1);
    checkOutput("midtrial_latency", lat_run, lat_golden);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
